mx_lane_arbiter: RTL and testbench

//  Shares the 3 output lanes of the 8-to-3 commutator among its 8 input sources.
//  - Sources raise req[i] to ask for a lane.
//  - Block assigns free lanes round-robin and holds each grant while req stays high.
//  - Forcibly reclaims a lane after MAX_HOLD cycles when other sources are waiting.
//  - Drives the commutator 9-bit control word (3 x 3-bit select) plus per-lane valid.

---
 rtl/mx_pkg.sv | 20 ++
 rtl/mx_lane_arbiter_rr_pick.sv | 27 ++
 rtl/mx_lane_arbiter.sv | 114 +++++++++++
 tb/tb_mx_lane_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mx_pkg.sv
// Shared sizes, lane select type and control-word packing for the 8-to-3 commutator arbiter.
package mx_pkg;

  localparam int N_IN   = 8;
  localparam int N_LANE = 3;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] lane_sel_t;

  // Lane L occupies control[L*SEL_W +: SEL_W].
  function automatic logic [N_LANE*SEL_W-1:0] pack_control(input lane_sel_t sel [N_LANE]);
    logic [N_LANE*SEL_W-1:0] word;
    word = '0;
    for (int l = 0; l < N_LANE; l++) begin
      word[l*SEL_W +: SEL_W] = sel[l];
    end
    return word;
  endfunction

endpackage

// File: rtl/mx_lane_arbiter_rr_pick.sv
// Masked first-one search: returns the first set bit of vec at or after ptr, wrapping mod N_IN.
module mx_rr_pick
  import mx_pkg::*;
(
  input  logic [N_IN-1:0]  vec,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] pos;

  // Scan from the far end back toward ptr so the closest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      pos = SEL_W'((int'(ptr) + k) % N_IN);
      if (vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mx_lane_arbiter.sv
// Round-robin lane arbiter for the 8-to-3 commutator: release, preempt after MAX_HOLD, allocate idle lanes.
module mx_lane_arbiter
  import mx_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         req,
  output logic [N_LANE*SEL_W-1:0] control,
  output logic [N_LANE-1:0]       lane_valid,
  output logic [N_IN-1:0]         grant,
  output logic [N_IN-1:0]         waiting
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  lane_sel_t         owner     [N_LANE];
  lane_sel_t         owner_nxt [N_LANE];
  logic [HOLD_W-1:0] hold_cnt  [N_LANE];
  logic [HOLD_W-1:0] hold_nxt  [N_LANE];
  logic [N_LANE-1:0] valid_nxt;
  logic [N_IN-1:0]   grant_nxt;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_nxt;
  logic              drop;

  logic [N_LANE-1:0] pick_found;
  lane_sel_t         pick_idx [N_LANE];

  assign waiting = req & ~grant;

  // Each lane sees the waiting set minus whatever earlier idle lanes already took.
  for (genvar l = 0; l < N_LANE; l++) begin : g_lane
    logic [N_IN-1:0]  vin;
    logic [N_IN-1:0]  vout;
    logic             found;
    logic [SEL_W-1:0] idx;

    if (l == 0) begin : g_head
      assign vin = waiting;
    end else begin : g_tail
      assign vin = g_lane[l-1].vout;
    end

    mx_rr_pick u_pick (
      .vec   (vin),
      .ptr   (rr_ptr),
      .found (found),
      .idx   (idx)
    );

    assign vout          = (found && !lane_valid[l]) ? (vin & ~(N_IN'(1) << idx)) : vin;
    assign pick_found[l] = found;
    assign pick_idx[l]   = idx;
  end

  always_comb begin
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    valid_nxt = lane_valid;
    grant_nxt = '0;
    rr_nxt    = rr_ptr;
    drop      = 1'b0;
    for (int l = 0; l < N_LANE; l++) begin
      if (lane_valid[l]) begin
        drop = !req[owner[l]] ||
               ((MAX_HOLD != 0) && (hold_cnt[l] == HOLD_W'(MAX_HOLD)) && (|waiting));
        if (drop) begin
          valid_nxt[l] = 1'b0;
          owner_nxt[l] = '0;
          hold_nxt[l]  = '0;
        end else if (hold_cnt[l] != HOLD_W'(MAX_HOLD)) begin
          hold_nxt[l] = hold_cnt[l] + HOLD_W'(1);
        end
      end else if (pick_found[l]) begin
        // Lanes are walked in ascending order, so the last taker sets the pointer.
        valid_nxt[l] = 1'b1;
        owner_nxt[l] = pick_idx[l];
        hold_nxt[l]  = '0;
        rr_nxt       = SEL_W'((int'(pick_idx[l]) + 1) % N_IN);
      end
      if (valid_nxt[l]) begin
        grant_nxt[owner_nxt[l]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_valid <= '0;
      grant      <= '0;
      rr_ptr     <= '0;
      for (int l = 0; l < N_LANE; l++) begin
        owner[l]    <= '0;
        hold_cnt[l] <= '0;
      end
    end else begin
      lane_valid <= valid_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_nxt;
      for (int l = 0; l < N_LANE; l++) begin
        owner[l]    <= owner_nxt[l];
        hold_cnt[l] <= hold_nxt[l];
      end
    end
  end

  // Idle lanes keep owner at zero, so the select fields of idle lanes read as 0.
  always_comb begin
    control = pack_control(owner);
  end

endmodule

// File: tb/tb_mx_lane_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD 16 and 4) against a queue-based lane model plus literal checks.
module tb_mx_lane_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;

  logic [8:0] ctrl_a, ctrl_b;
  logic [2:0] valid_a, valid_b;
  logic [7:0] grant_a, grant_b, wait_a, wait_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  mx_lane_arbiter dut_a (
    .clk(clk), .rst(rst), .req(req),
    .control(ctrl_a), .lane_valid(valid_a), .grant(grant_a), .waiting(wait_a)
  );

  mx_lane_arbiter #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .control(ctrl_b), .lane_valid(valid_b), .grant(grant_b), .waiting(wait_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][2:0] owner;
    logic [2:0]      valid;
    logic [2:0][4:0] hold;
    logic [2:0]      rr;
  } mstate_t;

  mstate_t ma = '0;
  mstate_t mb = '0;

  function automatic logic [7:0] m_grant(input mstate_t s);
    logic [7:0] g;
    g = '0;
    for (int l = 0; l < 3; l++) if (s.valid[l]) g[s.owner[l]] = 1'b1;
    return g;
  endfunction

  function automatic logic [8:0] m_ctrl(input mstate_t s);
    logic [8:0] c;
    c = '0;
    for (int l = 0; l < 3; l++) if (s.valid[l]) c[l*3 +: 3] = s.owner[l];
    return c;
  endfunction

  // One clock edge of the lane rules: release/preempt on held lanes, then
  // previously idle lanes take waiting sources in round-robin order.
  function automatic mstate_t mstep(input mstate_t s, input logic [7:0] r, input int mh);
    mstate_t    n;
    logic [7:0] w;
    int         q[$];
    int         src;
    n = s;
    w = r & ~m_grant(s);
    for (int l = 0; l < 3; l++) begin
      if (s.valid[l]) begin
        if (!r[s.owner[l]] || (mh != 0 && int'(s.hold[l]) == mh && w != 0)) begin
          n.valid[l] = 1'b0;
          n.owner[l] = '0;
          n.hold[l]  = '0;
        end else if (int'(s.hold[l]) < mh) begin
          n.hold[l] = s.hold[l] + 5'd1;
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      src = (int'(s.rr) + k) % 8;
      if (w[src]) q.push_back(src);
    end
    for (int l = 0; l < 3; l++) begin
      if (!s.valid[l] && q.size() > 0) begin
        src        = q.pop_front();
        n.valid[l] = 1'b1;
        n.owner[l] = 3'(src);
        n.hold[l]  = '0;
        n.rr       = 3'((src + 1) % 8);
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, req, 16);
      mb <= mstep(mb, req, 4);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_control", 32'(ctrl_a),  32'(m_ctrl(ma)));
      check("a_valid",   32'(valid_a), 32'(ma.valid));
      check("a_grant",   32'(grant_a), 32'(m_grant(ma)));
      check("a_waiting", 32'(wait_a),  32'(req & ~m_grant(ma)));
      check("b_control", 32'(ctrl_b),  32'(m_ctrl(mb)));
      check("b_valid",   32'(valid_b), 32'(mb.valid));
      check("b_grant",   32'(grant_b), 32'(m_grant(mb)));
      check("b_waiting", 32'(wait_b),  32'(req & ~m_grant(mb)));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick(1);
    rst = 1'b0;
  endtask

  logic [7:0] vec_tbl [12] = '{8'h3C, 8'hF0, 8'h00, 8'h55, 8'hAA, 8'hFF,
                               8'h0F, 8'hF7, 8'h01, 8'hFE, 8'hC3, 8'h80};

  initial begin
    rst = 1'b1;
    req = 8'h00;
    tick(1);
    chk_en = 1'b1;

    // idle after reset
    tick(1);
    rst = 1'b0;
    tick(5);
    check("t1_control", 32'(ctrl_a), 32'h0);
    check("t1_valid",   32'(valid_a), 32'h0);
    check("t1_grant",   32'(grant_a), 32'h0);

    // two requesters, pointer wraps past 7
    do_reset();
    req = 8'h81;
    tick(1);
    check("t2_control", 32'(ctrl_a), 32'h038);
    check("t2_valid",   32'(valid_a), 32'h3);
    check("t2_grant",   32'(grant_a), 32'h81);
    check("t2_model_rr", 32'(ma.rr), 32'h0);

    // full load, then release lane1 with a one-cycle bubble
    do_reset();
    req = 8'hFF;
    tick(1);
    check("t3_control", 32'(ctrl_a), 32'h088);
    check("t3_valid",   32'(valid_a), 32'h7);
    req = 8'hFD;
    tick(1);
    check("t3_bubble_valid",   32'(valid_a), 32'h5);
    check("t3_bubble_control", 32'(ctrl_a), 32'h080);
    tick(1);
    check("t3_realloc_control", 32'(ctrl_a), 32'h098);
    check("t3_realloc_grant",   32'(grant_a), 32'h0D);
    check("t3_realloc_waiting", 32'(wait_a), 32'hF0);

    // preemption with MAX_HOLD=4
    do_reset();
    req = 8'h0F;
    tick(6);
    check("t4_preempt_valid",   32'(valid_b), 32'h0);
    check("t4_preempt_waiting", 32'(wait_b), 32'h0F);
    check("t4_nopreempt_a",     32'(valid_a), 32'h7);
    tick(1);
    check("t4_control", 32'(ctrl_b), 32'h043);
    check("t4_valid",   32'(valid_b), 32'h7);
    check("t4_grant",   32'(grant_b), 32'h0B);
    check("t4_waiting", 32'(wait_b), 32'h04);

    // no waiters: counters saturate, preempt fires on the first waiter
    do_reset();
    req = 8'h07;
    tick(10);
    check("t5_saturated_valid", 32'(valid_b), 32'h7);
    req = 8'h0F;
    tick(1);
    check("t5_preempt_valid", 32'(valid_b), 32'h0);
    check("t5_a_kept",        32'(valid_a), 32'h7);
    check("t5_a_waiting",     32'(wait_a), 32'h08);

    // reset mid-operation
    req = 8'hFF;
    tick(2);
    check("t6_busy", 32'(valid_a), 32'h7);
    rst = 1'b1;
    tick(1);
    check("t6_rst_valid",   32'(valid_a), 32'h0);
    check("t6_rst_control", 32'(ctrl_a), 32'h0);
    check("t6_rst_grant",   32'(grant_a), 32'h0);
    check("t6_rst_valid_b", 32'(valid_b), 32'h0);
    rst = 1'b0;
    req = 8'h10;
    tick(1);
    check("t6_control", 32'(ctrl_a), 32'h004);
    check("t6_valid",   32'(valid_a), 32'h1);
    check("t6_grant",   32'(grant_a), 32'h10);

    // directed mix, model-checked every cycle
    for (int i = 0; i < 12; i++) begin
      req = vec_tbl[i];
      tick(3);
    end
    req = 8'hFF;
    tick(40);
    req = 8'h00;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
